// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the seven-level interrupt controller: register map,
// access FSM encoding, reset constants and the priority encoder.
package int_ctrl_pkg;

    localparam logic [3:0] REG_PEND  = 4'h0;
    localparam logic [3:0] REG_MASK  = 4'h1;
    localparam logic [3:0] REG_VBASE = 4'h2;
    localparam logic [3:0] REG_SWINT = 4'h3;
    localparam logic [3:0] REG_CLR   = 4'h4;

    localparam logic [7:0] MASK_RST  = 8'h80;
    localparam logic [7:0] VBASE_RST = 8'h40;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_HOLD = 2'd3
    } acc_state_e;

    // Active-low IPL of the highest active level; 3'b111 when nothing is active.
    function automatic logic [2:0] ipl_encode(input logic [7:1] active);
        logic [2:0] lvl;
        lvl = 3'd0;
        for (int i = 1; i <= 7; i++) begin
            if (active[i]) begin
                lvl = 3'(i);
            end
        end
        return ~lvl;
    endfunction

endpackage

// File: rtl/int_sync_edge.sv
// Multi-stage synchronizer for asynchronous interrupt sources followed by a
// rising-edge detector on the synchronized value.
module int_sync_edge #(
    parameter int SYNC_STAGES = 2,
    parameter int WIDTH       = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] src_i,
    output logic [WIDTH-1:0] rise_o
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;

    // Synchronizer chain and previous-value flop for edge detection.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= {WIDTH{1'b0}};
            end
            prev_q <= {WIDTH{1'b0}};
        end else begin
            sync_q[0] <= src_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/int_ctrl.sv
// Seven-level interrupt controller: edge-latched sources, mask, priority IPL
// output, register bus and IACK handling through one shared access FSM.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int         SYNC_STAGES  = 2,
    parameter logic [7:0] SPURIOUS_VEC = 8'h18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_stb,
    input  logic        bus_we,
    input  logic [3:0]  bus_addr,
    input  logic [7:0]  bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_ack,
    input  logic        iack_stb,
    input  logic [2:0]  iack_level,
    output logic [7:0]  iack_vector,
    output logic        iack_ack,
    input  logic [6:0]  src,
    output logic [2:0]  out_ipl
);

    acc_state_e  state_q;
    logic        sel_iack_q;
    logic        bus_ack_q;
    logic        iack_ack_q;
    logic [31:0] bus_rdata_q;
    logic [7:0]  iack_vector_q;
    logic [7:1]  pend_q, pend_d;
    logic [7:0]  mask_q, mask_d;
    logic [4:0]  vbase_q, vbase_d;
    logic [2:0]  out_ipl_q;

    logic [6:0]  src_rise_s;
    logic        wr_s;
    logic        iack_hit_s;
    logic [7:0]  pend_full_s;
    logic [7:0]  swint_oh_s;
    logic [7:0]  iack_oh_s;
    logic [7:1]  set_s, clr_s;
    logic [31:0] rdata_s;
    logic [7:0]  vector_s;

    int_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES),
        .WIDTH      (7)
    ) u_sync_edge (
        .clk   (clk),
        .rst   (rst),
        .src_i (src),
        .rise_o(src_rise_s)
    );

    // Register read mux, IACK decode and next-state of pending/MASK/VBASE.
    // Side effects are applied on the edge that enters ACK, so they land in the ack cycle.
    always_comb begin
        wr_s        = (state_q == ST_WAIT) && !sel_iack_q && bus_we;
        pend_full_s = {pend_q, 1'b0};
        iack_hit_s  = (state_q == ST_WAIT) && sel_iack_q && pend_full_s[iack_level];
        swint_oh_s  = 8'b0000_0001 << bus_wdata[2:0];
        iack_oh_s   = 8'b0000_0001 << iack_level;
        set_s       = src_rise_s;
        clr_s       = 7'd0;
        mask_d      = mask_q;
        vbase_d     = vbase_q;
        if (wr_s) begin
            case (bus_addr)
                REG_MASK:  mask_d  = {1'b1, bus_wdata[6:1], 1'b0};
                REG_VBASE: vbase_d = bus_wdata[7:3];
                REG_SWINT: set_s   = src_rise_s | swint_oh_s[7:1];
                REG_CLR:   clr_s   = bus_wdata[7:1];
                default:   clr_s   = 7'd0;
            endcase
        end else if (iack_hit_s) begin
            clr_s = iack_oh_s[7:1];
        end else begin
            clr_s = 7'd0;
        end
        pend_d = (pend_q & ~clr_s) | set_s;

        case (bus_addr)
            REG_PEND:  rdata_s = {24'd0, pend_q, 1'b0};
            REG_MASK:  rdata_s = {24'd0, mask_q};
            REG_VBASE: rdata_s = {24'd0, vbase_q, 3'b000};
            default:   rdata_s = 32'd0;
        endcase

        if (iack_hit_s) begin
            vector_s = {vbase_q, iack_level};
        end else begin
            vector_s = SPURIOUS_VEC;
        end
    end

    // Register file, pending latch and registered priority output.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_q    <= 7'd0;
            mask_q    <= MASK_RST;
            vbase_q   <= VBASE_RST[7:3];
            out_ipl_q <= 3'b111;
        end else begin
            pend_q    <= pend_d;
            mask_q    <= mask_d;
            vbase_q   <= vbase_d;
            out_ipl_q <= ipl_encode(pend_q & mask_q[7:1]);
        end
    end

    // Shared access FSM with registered ack, read data and vector.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            sel_iack_q    <= 1'b0;
            bus_ack_q     <= 1'b0;
            iack_ack_q    <= 1'b0;
            bus_rdata_q   <= 32'd0;
            iack_vector_q <= 8'd0;
        end else begin
            bus_ack_q     <= 1'b0;
            iack_ack_q    <= 1'b0;
            bus_rdata_q   <= 32'd0;
            iack_vector_q <= 8'd0;
            case (state_q)
                ST_IDLE: begin
                    if (iack_stb) begin
                        state_q    <= ST_WAIT;
                        sel_iack_q <= 1'b1;
                    end else if (bus_stb) begin
                        state_q    <= ST_WAIT;
                        sel_iack_q <= 1'b0;
                    end else begin
                        state_q    <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    state_q <= ST_ACK;
                    if (sel_iack_q) begin
                        iack_ack_q    <= 1'b1;
                        iack_vector_q <= vector_s;
                    end else begin
                        bus_ack_q   <= 1'b1;
                        bus_rdata_q <= bus_we ? 32'd0 : rdata_s;
                    end
                end
                ST_ACK: begin
                    state_q <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (!(sel_iack_q ? iack_stb : bus_stb)) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_HOLD;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus_ack     = bus_ack_q;
    assign iack_ack    = iack_ack_q;
    assign bus_rdata   = bus_rdata_q;
    assign iack_vector = iack_vector_q;
    assign out_ipl     = out_ipl_q;

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Seven-level interrupt controller for the 68040 board. It latches edge-triggered interrupt sources, masks them, prioritises them, and drives the CPU IPL lines. It answers interrupt-acknowledge (IACK) cycles with a vector and clears the serviced request. It sits on the FPGA register bus behind the CPU address decoder and replaces the single software-written interrupt register.

## Interface
- SYNC_STAGES, 2: synchronizer depth for src inputs (≥2).
- SPURIOUS_VEC, 8'h18: vector returned when the acknowledged level has no pending request.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- bus_stb  in  1  register access request; held high until bus_ack.
- bus_we  in  1  1 = write, 0 = read; valid while bus_stb.
- bus_addr  in  4  register address.
- bus_wdata  in  8  write data.
- bus_rdata  out  32  read data; valid only in the bus_ack cycle, 0 otherwise.
- bus_ack  out  1  one-cycle access completion pulse.
- iack_stb  in  1  CPU IACK cycle request; held high until iack_ack.
- iack_level  in  3  level being acknowledged (CPU A3..A1), 1..7.
- iack_vector  out  8  vector; valid only in the iack_ack cycle, 0 otherwise.
- iack_ack  out  1  one-cycle IACK completion pulse.
- src  in  7  asynchronous sources; src[n-1] is level n; a rising edge requests.
- out_ipl  out  3  active-low encoded priority level to the CPU (3'b111 = none).

## Operation
- Registers (the addresses live in the package):
  - 0x0 PEND (R): bits[7:1] pending. Bit 0 reads 0.
  - 0x1 MASK (R/W): bit n enables level n. Bit 0 is ignored. Bit 7 reads 1 and is not writable, so level 7 is non-maskable.
  - 0x2 VBASE (R/W): bits[7:3] are the vector base. Bits[2:0] read 0.
  - 0x3 SWINT (W): sets pending[wdata[2:0]]. A value of 0 has no effect.
  - 0x4 CLR (W): write-1-to-clear pending[7:1].
  - Other addresses: reads return 0, writes are ignored, and the access is still acked.
- Each src bit passes through SYNC_STAGES flops plus an edge detector. A rising edge sets the matching pending bit.
- Pending bit update precedence, highest first:
  - reset
  - set (from src edge or SWINT)
  - clear (from CLR or IACK)
  - A set and a clear in the same cycle leave the bit set.
- Priority: active = pending & MASK. out_ipl = ~(index of the highest set bit of active), or 3'b111 if active is 0. out_ipl is registered and reflects the pending/MASK state of the previous cycle.
- IACK:
  - If pending[iack_level] = 1: iack_vector = {VBASE[7:3], iack_level}, and pending[iack_level] clears in the ack cycle.
  - Otherwise, including iack_level = 0: iack_vector = SPURIOUS_VEC and no state changes.
- Shared access FSM with states IDLE, WAIT, ACK, HOLD:
  - IDLE: iack_stb → WAIT(iack). Otherwise bus_stb → WAIT(bus). IACK wins when both strobes are high.
  - WAIT → ACK after one cycle.
  - ACK: asserts exactly one of bus_ack or iack_ack. Register write or IACK side effects occur here. Next state is HOLD.
  - HOLD: stays until the served strobe is low, then → IDLE. This ensures one access per strobe assertion.
- Reset values:
  - FSM IDLE.
  - pending = 0, MASK = 8'h80, VBASE = 8'h40.
  - out_ipl = 3'b111, bus_ack = 0, iack_ack = 0, bus_rdata = 0, iack_vector = 0.
  - Synchronizer and edge flops = 0, so a src already high at reset does not request.
- Reset mid-access: the FSM returns to IDLE with no ack, and a pending write is discarded. The master must restart the access.

## Timing
- Strobe first sampled high at edge N → ack is high in cycle N+2 for exactly one cycle.
- Back-to-back accesses: a new strobe is sampled no earlier than the edge after the previous strobe is seen low.
- Source latency: src rising edge → pending set after SYNC_STAGES+1 clocks → out_ipl changes one clock later.
- Writes to MASK or CLR affect out_ipl in cycle N+3.
- IACK clear → out_ipl drops to the next level (or 3'b111) in cycle N+3.
- bus_rdata and iack_vector are driven only in their ack cycle, and are 0 in all other cycles.

## Structure
- int_ctrl_pkg contains:
  - register address constants (REG_PEND, REG_MASK, REG_VBASE, REG_SWINT, REG_CLR);
  - FSM state encoding;
  - the MASK and VBASE reset constants.
- Sub-module int_sync_edge: parameterised SYNC_STAGES synchronizer plus rising-edge detector. It is instantiated seven times (or once, 7 bits wide).
- The top level holds the FSM, the register file, the pending logic and the priority encoder.

## Test plan
- Reset, then pulse src[4] (level 5) high → out_ipl stays 3'b111 while MASK = 8'h80. Write MASK = 8'h20 → out_ipl = 3'b010 three cycles after the strobe edge.
- Level 3 and level 6 pending with MASK = 8'hFE → out_ipl = 3'b001. An IACK at level 6 with VBASE = 8'h40 → iack_vector = 8'h46, and out_ipl becomes 3'b100 (level 3) one cycle after the ack.
- IACK at level 2 with nothing pending → iack_vector = 8'h18, and PEND is unchanged.
- A src[6] edge while MASK = 8'h00 → out_ipl = 3'b000 (non-maskable). Reading MASK returns 32'h80.
- bus_stb and iack_stb raised in the same cycle → iack_ack arrives first. bus_ack follows two cycles after bus_stb is sampled again in IDLE. Each strobe produces exactly one ack even when held high for 10 cycles.
- CLR write of 8'h08 in the same cycle a level-3 edge sets pending → PEND bit 3 remains set. Asserting rst during WAIT → no ack, and all registers are at their reset values.
